// File: rtl/wb_ram_resp.sv
// wb_ram_resp: Wishbone-classic word RAM responder with byte-lane writes and window decode.
// Latency: ack is presented WAIT+1 cycles after cyc is raised, for one cycle; acks are spaced WAIT+2 apart.
// Backpressure: wait states only; dropping cyc while waiting aborts, out-of-window accesses still ack.
module wb_ram_resp #(
  parameter int unsigned WORDS     = 512,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned WAIT      = 1
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        cyc,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        ack,
  output logic [31:0] rdt
);

  localparam int unsigned AW = $clog2(WORDS);

  // Only bits above the RAM's byte span take part in the window decode.
  localparam logic [31:0] WIN_MASK = ~((32'd1 << (AW + 2)) - 32'd1);

  // Counter preload on leaving IDLE; the WAIT == 0 path never uses it.
  localparam logic [3:0] WAIT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAITING = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          access;
  logic          hit;
  logic [AW-1:0] idx;
  logic          mem_we;
  logic [31:0]   mem [WORDS];

  assign hit = (adr & WIN_MASK) == (ADDR_BASE & WIN_MASK);
  assign idx = adr[AW+1:2];

  // Sequencing: count wait states, abort on cyc drop, then one ACK cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cyc) begin
          if (WAIT == 0) begin
            access  = 1'b1;
            state_d = ST_ACK;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAITING;
          end
        end
      end
      ST_WAITING: begin
        if (!cyc) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The ack register is exactly "the access happened on the last edge".
  always_comb begin
    ack_d = access;
    rdt_d = 32'd0;
    if (access && !we && hit) begin
      rdt_d = mem[idx];
    end
  end

  // A WAIT == 0 responder sees access in IDLE even under reset, so the write is gated by it.
  assign mem_we = access & we & hit & wb_rst;

  // Control and read-data registers; RAM contents are deliberately outside this reset.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      rdt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
    end
  end

  // RAM write port: enabled byte lanes commit on the edge that enters ACK.
  always_ff @(posedge wb_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) begin
          mem[idx][8*b +: 8] <= dat[8*b +: 8];
        end
      end
    end
  end

  // A dropped cyc kills ack at once; rdt is forced to zero whenever ack is low.
  assign ack = ack_q & cyc;
  assign rdt = ack ? rdt_q : 32'd0;

endmodule

// File: tb/tb_wb_ram_resp.sv
// tb_wb_ram_resp: three responders (WAIT = 0, 1, 3) against a transaction-level model.
// Latency: the model counts consecutive cyc-high edges and acks after WAIT+1 of them.
// Backpressure: initiator randomly drops cyc to exercise aborts and ack masking.
module tb_wb_ram_resp;

  localparam int          WORDS = 512;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc_a [3];
  logic        we_a  [3];
  logic [3:0]  sel_a [3];
  logic [31:0] adr_a [3];
  logic [31:0] dat_a [3];
  logic        ack_a [3];
  logic [31:0] rdt_a [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_ram_resp #(
      .WORDS     (WORDS),
      .ADDR_BASE (BASE),
      .WAIT      (wait_of(g))
    ) u_dut (
      .wb_clk (clk),
      .wb_rst (rst_n),
      .cyc    (cyc_a[g]),
      .we     (we_a[g]),
      .sel    (sel_a[g]),
      .adr    (adr_a[g]),
      .dat    (dat_a[g]),
      .ack    (ack_a[g]),
      .rdt    (rdt_a[g])
    );
  end

  // Reference model: per responder a run length of cyc-high edges, an ack flag and a word store.
  int          run_m     [3];
  bit          in_ack_m  [3];
  logic [31:0] exp_rdt_m [3];
  logic [31:0] exp_msk_m [3];
  logic [31:0] mem_m     [3][WORDS];
  bit   [31:0] kn_m      [3][WORDS];
  logic [31:0] m_off;
  int          m_idx;
  bit          m_hit;

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        run_m[k]    = 0;
        in_ack_m[k] = 1'b0;
      end else if (in_ack_m[k]) begin
        in_ack_m[k] = 1'b0;
        run_m[k]    = 0;
      end else if (cyc_a[k]) begin
        run_m[k] = run_m[k] + 1;
        if (run_m[k] == wait_of(k) + 1) begin
          m_off = adr_a[k] - BASE;
          m_hit = (m_off < 32'(WORDS * 4));
          m_idx = int'(m_off >> 2);
          exp_rdt_m[k] = 32'd0;
          exp_msk_m[k] = 32'hffff_ffff;
          if (we_a[k]) begin
            exp_msk_m[k] = 32'd0;
            if (m_hit) begin
              for (int b = 0; b < 4; b++) begin
                if (sel_a[k][b]) begin
                  mem_m[k][m_idx][8*b +: 8] = dat_a[k][8*b +: 8];
                  kn_m[k][m_idx][8*b +: 8]  = 8'hff;
                end
              end
            end
          end else if (m_hit) begin
            exp_rdt_m[k] = mem_m[k][m_idx];
            exp_msk_m[k] = kn_m[k][m_idx];
          end
          in_ack_m[k] = 1'b1;
          run_m[k]    = 0;
        end
      end else begin
        run_m[k] = 0;
      end
    end
  end

  // Every cycle, every responder: ack and rdt against the model.
  logic        e_ack;
  logic [31:0] e_rdt, e_msk;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      e_ack = in_ack_m[k] & cyc_a[k];
      e_rdt = e_ack ? exp_rdt_m[k] : 32'd0;
      e_msk = e_ack ? exp_msk_m[k] : 32'hffff_ffff;
      n_cmp++;
      if (ack_a[k] !== e_ack) begin
        n_bad++;
        $display("FAIL model_ack[%0d] t=%0t: got %b want %b", k, $time, ack_a[k], e_ack);
      end
      n_cmp++;
      if ((rdt_a[k] & e_msk) !== (e_rdt & e_msk)) begin
        n_bad++;
        $display("FAIL model_rdt[%0d] t=%0t: got %h want %h (mask %h)", k, $time, rdt_a[k], e_rdt, e_msk);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer on responder k: checks latency, single-cycle ack and rdt clearing.
  task automatic xfer(input int k, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    int lat;
    lat = -1;
    rd  = 32'd0;
    cyc_a[k] = 1'b1; we_a[k] = w; sel_a[k] = s; adr_a[k] = a; dat_a[k] = d;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (ack_a[k]) begin
        lat = c;
        rd  = rdt_a[k];
      end
      tick();
    end
    chk("ack_latency", 32'(lat), 32'(wait_of(k) + 1));
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, ack_a[k]}, 32'd0);
    chk("rdt_after_ack", rdt_a[k], 32'd0);
    #1;
    cyc_a[k] = 1'b0;
    we_a[k]  = 1'b0;
    tick();
  endtask

  logic [31:0] rd;
  logic [31:0] b2b_val [4];
  int          got, last, cyc_n;

  initial begin
    b2b_val = '{32'h0a0b_0c0d, 32'h1111_2222, 32'h3333_4444, 32'hfeed_f00d};

    // Reset held with every initiator requesting a write.
    for (int k = 0; k < 3; k++) begin
      cyc_a[k] = 1'b1; we_a[k] = 1'b1; sel_a[k] = 4'hf; adr_a[k] = BASE; dat_a[k] = 32'hffff_ffff;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("reset_ack", {31'd0, ack_a[k]}, 32'd0);
        chk("reset_rdt", rdt_a[k], 32'd0);
      end
      tick();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc_a[k] = 1'b0;
    tick();

    // WAIT = 1: write/read, byte lanes, sel = 0, window miss.
    xfer(1, 1'b1, 4'hf, 32'h8000_0020, 32'h1234_3456, rd);
    xfer(1, 1'b0, 4'h0, 32'h8000_0020, 32'h0, rd);
    chk("readback", rd, 32'h1234_3456);
    xfer(1, 1'b1, 4'hf, 32'h8000_0010, 32'hcafe_cafe, rd);
    xfer(1, 1'b1, 4'b0101, 32'h8000_0010, 32'h1122_3344, rd);
    xfer(1, 1'b0, 4'hf, 32'h8000_0010, 32'h0, rd);
    chk("byte_lanes", rd, 32'hca22_ca44);
    xfer(1, 1'b1, 4'h0, 32'h8000_0010, 32'hffff_ffff, rd);
    xfer(1, 1'b0, 4'hf, 32'h8000_0010, 32'h0, rd);
    chk("sel_zero", rd, 32'hca22_ca44);
    xfer(1, 1'b1, 4'hf, 32'h0000_0020, 32'hdead_beef, rd);
    xfer(1, 1'b0, 4'hf, 32'h8000_0020, 32'h0, rd);
    chk("miss_write", rd, 32'h1234_3456);
    xfer(1, 1'b0, 4'hf, 32'h0000_0020, 32'h0, rd);
    chk("miss_read", rd, 32'h0);

    // WAIT = 3: abort after two cycles leaves RAM untouched.
    xfer(2, 1'b1, 4'hf, 32'h8000_0040, 32'h5555_aaaa, rd);
    cyc_a[2] = 1'b1; we_a[2] = 1'b1; sel_a[2] = 4'hf; adr_a[2] = 32'h8000_0040; dat_a[2] = 32'h0bad_0bad;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_ack", {31'd0, ack_a[2]}, 32'd0);
      tick();
      if (i == 1) cyc_a[2] = 1'b0;
    end
    xfer(2, 1'b0, 4'hf, 32'h8000_0040, 32'h0, rd);
    chk("abort_no_write", rd, 32'h5555_aaaa);

    // WAIT = 0: four back-to-back reads with cyc held high.
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 4'hf, 32'h8000_0100 + 32'(4 * i), b2b_val[i], rd);
    cyc_a[0] = 1'b1; we_a[0] = 1'b0; adr_a[0] = 32'h8000_0100;
    got = 0; last = -1; cyc_n = 0;
    while (got < 4 && cyc_n < 40) begin
      @(negedge clk);
      if (ack_a[0]) begin
        chk("b2b_data", rdt_a[0], b2b_val[got]);
        if (got > 0) chk("b2b_spacing", 32'(cyc_n - last), 32'd2);
        last = cyc_n;
        got++;
        tick();
        adr_a[0] = 32'h8000_0100 + 32'(4 * got);
      end else begin
        tick();
      end
      cyc_n++;
    end
    chk("b2b_count", 32'(got), 32'd4);
    cyc_a[0] = 1'b0;
    tick();

    // Reset with a WAIT = 0 write pending must not commit it.
    xfer(0, 1'b1, 4'hf, 32'h8000_0080, 32'h7777_1111, rd);
    cyc_a[0] = 1'b1; we_a[0] = 1'b1; sel_a[0] = 4'hf; adr_a[0] = 32'h8000_0080; dat_a[0] = 32'h0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid_ack", {31'd0, ack_a[0]}, 32'd0);
      tick();
    end
    rst_n = 1'b1;
    cyc_a[0] = 1'b0;
    tick();
    xfer(0, 1'b0, 4'hf, 32'h8000_0080, 32'h0, rd);
    chk("rst_no_write", rd, 32'h7777_1111);

    // Random traffic with occasional reset pulses; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 3; k++) begin
        cyc_a[k] = ($urandom_range(0, 3) != 0);
        we_a[k]  = 1'($urandom_range(0, 1));
        sel_a[k] = 4'($urandom_range(0, 15));
        dat_a[k] = $urandom;
        if ($urandom_range(0, 7) == 0) adr_a[k] = $urandom & 32'h7fff_ffff;
        else adr_a[k] = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      end
      tick();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc_a[k] = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
